// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and
// restoring divide on magnitudes, followed by one sign-correction cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        neg_2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic               busy_r;
    logic               busy_s;
    logic               done_r;
    logic               done_s;
    logic [CW-1:0]      count_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opb_r;
    logic [WIDTH-1:0]   a_raw_r;
    logic               is_div_r;
    logic               neg_lo_r;
    logic               neg_hi_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               signed_op_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic               div_fits_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    assign signed_op_s = ~op[0];
    assign a_mag_s = (signed_op_s && operand_a[WIDTH-1]) ? neg_w(operand_a) : operand_a;
    assign b_mag_s = (signed_op_s && operand_b[WIDTH-1]) ? neg_w(operand_b) : operand_b;

    // Multiply step: acc = {partial product, remaining multiplier bits}; carry enters at the top.
    assign mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                        (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend/quotient}; the 33-bit shifted remainder is compared first
    // so the 32-bit difference below never wraps when it is used.
    assign div_fits_s = acc_r[2*WIDTH-1:WIDTH-1] >= {1'b0, opb_r};
    assign div_rem_s  = acc_r[2*WIDTH-2:WIDTH-1] - opb_r;
    assign div_next_s = div_fits_s ? {div_rem_s, acc_r[WIDTH-2:0], 1'b1}
                                   : {acc_r[2*WIDTH-2:0], 1'b0};

    assign product_s = neg_lo_r ? neg_2w(acc_r) : acc_r;

    // Sign correction and result selection for the FIX cycle.
    always_comb begin
        fix_hi_s = product_s[2*WIDTH-1:WIDTH];
        fix_lo_s = product_s[WIDTH-1:0];
        if (div_zero_r) begin
            fix_hi_s = a_raw_r;
            fix_lo_s = {WIDTH{1'b1}};
        end else if (is_div_r) begin
            fix_hi_s = neg_hi_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
            fix_lo_s = neg_lo_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        end else begin
            fix_hi_s = product_s[2*WIDTH-1:WIDTH];
            fix_lo_s = product_s[WIDTH-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (count_r == LAST_STEP) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode, registered alongside the state.
    always_comb begin
        busy_s = (state_s != ST_IDLE);
        done_s = (state_r == ST_FIX);
    end

    // State and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Operand capture, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r    <= {CW{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            opb_r      <= {WIDTH{1'b0}};
            a_raw_r    <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            neg_lo_r   <= 1'b0;
            neg_hi_r   <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        count_r    <= {CW{1'b0}};
                        acc_r      <= {{WIDTH{1'b0}}, a_mag_s};
                        opb_r      <= b_mag_s;
                        a_raw_r    <= operand_a;
                        is_div_r   <= op[1];
                        neg_lo_r   <= signed_op_s & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        neg_hi_r   <= signed_op_s & op[1] & operand_a[WIDTH-1];
                        div_zero_r <= op[1] & (operand_b == {WIDTH{1'b0}});
                    end else begin
                        if (mthi) begin
                            hi_r <= operand_a;
                        end
                        if (mtlo) begin
                            lo_r <= operand_a;
                        end
                    end
                end
                ST_CALC: begin
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    acc_r   <= is_div_r ? div_next_s : mul_next_s;
                end
                ST_FIX: begin
                    hi_r <= fix_hi_s;
                    lo_r <= fix_lo_s;
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic reference.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = 32'h0;
        l = 32'h0;
        case (o)
            2'b00: begin
                sp = sa * sb;
                h = sp[63:32];
                l = sp[31:0];
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                h = up[63:32];
                l = up[31:0];
            end
            2'b10, 2'b11: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (o == 2'b10) begin
                    sp = sa / sb;
                    l = sp[31:0];
                    sp = sa % sb;
                    h = sp[31:0];
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one operation, watch it to completion and compare with the expected HI/LO.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noisy, input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] ph;
        logic [31:0] pl;
        int          n_busy;
        int          edge_k;
        bit          changed;
        ph = hi;
        pl = lo;
        n_busy = 0;
        edge_k = 0;
        changed = 1'b0;
        op = o;
        operand_a = a;
        operand_b = b;
        start = 1'b1;
        mthi = noisy;
        mtlo = noisy;
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        check_val({tag, "_busy_e0"}, {63'd0, busy}, 64'd1);
        check_val({tag, "_done_e0"}, {63'd0, done}, 64'd0);
        if (busy === 1'b1) n_busy++;
        if (hi !== ph || lo !== pl) changed = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (noisy && k == 5) begin
                start = 1'b1;
                mthi = 1'b1;
                mtlo = 1'b1;
                operand_a = 32'hA5A5_A5A5;
                operand_b = 32'h0000_0003;
            end else if (noisy && k == 6) begin
                start = 1'b0;
                mthi = 1'b0;
                mtlo = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                edge_k = k;
                break;
            end
            if (busy === 1'b1) n_busy++;
            if (hi !== ph || lo !== pl) changed = 1'b1;
        end
        check_val({tag, "_latency"}, 64'(edge_k), 64'd33);
        check_val({tag, "_busy_cycles"}, 64'(n_busy), 64'd33);
        check_val({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        check_val({tag, "_hilo_stable"}, {63'd0, changed}, 64'd0);
        check_val({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check_val({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eh;
        logic [31:0] el;
        int          sel;
        bit          done_seen;

        reset_n = 1'b0;
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        op = 2'b00;
        operand_a = 32'h0;
        operand_b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_hi", {32'd0, hi}, 64'd0);
        check_val("rst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, issued back to back on the done cycle.
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 2'b11, 32'd100, 32'd7, 1'b0, 32'h0000_0002, 32'h0000_000E);
        run_op("divu_zero", 2'b11, 32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'h0, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0);
        @(posedge clk);
        #1;
        check_val("done_width", {63'd0, done}, 64'd0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'h0;
            else if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) ra = 32'($urandom_range(0, 255));
            ref_model(ro, ra, rb, eh, el);
            run_op("rand", ro, ra, rb, (i % 5) == 0, eh, el);
        end

        // Idle moves into HI/LO.
        operand_a = 32'hCAFE_F00D;
        mthi = 1'b1;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        check_val("mthi_idle", {32'd0, hi}, {32'd0, 32'hCAFE_F00D});
        operand_a = 32'h0000_1234;
        mtlo = 1'b1;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check_val("mtlo_idle", {32'd0, lo}, {32'd0, 32'h0000_1234});
        check_val("mtlo_keeps_hi", {32'd0, hi}, {32'd0, 32'hCAFE_F00D});

        // Reset in the middle of a multiply.
        op = 2'b00;
        operand_a = 32'd5;
        operand_b = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("abort_busy", {63'd0, busy}, 64'd0);
        check_val("abort_done", {63'd0, done}, 64'd0);
        check_val("abort_hi", {32'd0, hi}, 64'd0);
        check_val("abort_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        check_val("abort_no_done", {63'd0, done_seen}, 64'd0);
        operand_a = 32'h0000_0011;
        mtlo = 1'b1;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check_val("abort_mtlo", {32'd0, lo}, {32'd0, 32'h0000_0011});
        run_op("post_abort", 2'b00, 32'd5, 32'd5, 1'b0, 32'h0, 32'd25);

        // Start on the very first edge after a reset release.
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        run_op("first_edge", 2'b11, 32'd1000, 32'd33, 1'b0, 32'd10, 32'd30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
